// File: rtl/immgen_pipe.sv
// immgen_pipe: RISC-V immediate generator with a registered output stage and
// a one-entry skid buffer. Decode is combinational on i_inst; the decoded
// entry lands in the main register one cycle after accept.
// Optional feature: define IMMGEN_PIPE_ZICSR_EN to decode SYSTEM (1110011)
// as CSR immediates; otherwise that opcode is reported illegal.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TYPEW = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [TYPEW-1:0] o_imm_type,
  output logic             o_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TYPEW-1:0] typ;
    logic             illegal;
  } entry_t;

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_I    = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_S    = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_B    = TYPEW'(3);
  localparam logic [TYPEW-1:0] T_U    = TYPEW'(4);
  localparam logic [TYPEW-1:0] T_J    = TYPEW'(5);
`ifdef IMMGEN_PIPE_ZICSR_EN
  localparam logic [TYPEW-1:0] T_CSRZ = TYPEW'(6);
`endif
  localparam bit RV64 = (XLEN == 64);

  entry_t dec, main_q, skid_q;
  logic   main_v, skid_v;
  logic   accept, xfer;

  logic [6:0]         opc;
  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign opc   = i_inst[6:0];
  assign imm_i = i_inst[31:20];
  assign imm_s = {i_inst[31:25], i_inst[11:7]};
  assign imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};

  // Combinational decode of the offered instruction; unknown opcodes
  // (including any with inst[1:0] != 2'b11) fall through to illegal.
  always_comb begin
    dec.imm     = '0;
    dec.typ     = T_NONE;
    dec.illegal = 1'b0;
    unique casez (opc)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.imm = XLEN'(imm_i);
        dec.typ = T_I;
      end
      7'b0011011: begin
        if (RV64) begin
          dec.imm = XLEN'(imm_i);
          dec.typ = T_I;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec.imm = XLEN'(imm_s);
        dec.typ = T_S;
      end
      7'b1100011: begin
        dec.imm = XLEN'(imm_b);
        dec.typ = T_B;
      end
      7'b1101111: begin
        dec.imm = XLEN'(imm_j);
        dec.typ = T_J;
      end
      7'b0110111, 7'b0010111: begin
        dec.imm = XLEN'(imm_u);
        dec.typ = T_U;
      end
      7'b0110011: ;
      7'b0111011: dec.illegal = !RV64;
`ifdef IMMGEN_PIPE_ZICSR_EN
      7'b1110011: begin
        if (i_inst[14]) begin
          dec.imm = XLEN'(i_inst[19:15]);
          dec.typ = T_CSRZ;
        end else begin
          dec.imm = XLEN'(imm_i);
          dec.typ = T_I;
        end
      end
`endif
      default: dec.illegal = 1'b1;
    endcase
  end

  assign accept = i_valid && o_ready;
  assign xfer   = main_v && i_ready;

  // Main/skid occupancy and data. Skid only fills while main is stalled,
  // and drains into main on the next transfer, so ordering is preserved.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (i_flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (xfer) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign o_ready    = !skid_v;
  assign o_valid    = main_v;
  assign o_imm      = main_q.imm;
  assign o_imm_type = main_q.typ;
  assign o_illegal  = main_q.illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: decode vectors, skid behaviour, flush,
// asynchronous reset, plus an XLEN=64 instance for the wide cases.
module tb_immgen_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] i_inst = '0;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_imm;
  logic [2:0]  o_imm_type;

  logic        v64 = 1'b0;
  logic [31:0] inst64 = '0;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  typ64;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  immgen_pipe #(.XLEN(32), .TYPEW(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
    .o_valid(o_valid), .i_ready(i_ready), .o_imm(o_imm),
    .o_imm_type(o_imm_type), .o_illegal(o_illegal)
  );

  immgen_pipe #(.XLEN(64), .TYPEW(3)) dut64 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(1'b0),
    .i_valid(v64), .o_ready(rdy64), .i_inst(inst64),
    .o_valid(ov64), .i_ready(1'b1), .o_imm(imm64),
    .o_imm_type(typ64), .o_illegal(ill64)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 32'h0 ||
        o_imm_type !== 3'd0 || o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b imm=%h type=%0d ill=%b want 0 1 0 0 0",
               o_valid, o_ready, o_imm, o_imm_type, o_illegal);
    end
    i_rst_n = 1'b1;
    step();
  endtask

  // Single-entry decode vectors through the 32-bit instance.
  task automatic test_decode();
    logic [31:0] vin  [9];
    logic [31:0] vimm [9];
    logic [2:0]  vtyp [9];
    logic        vill [9];
    vin[0] = 32'hFFF00093; vimm[0] = 32'hFFFFFFFF; vtyp[0] = 3'd1; vill[0] = 1'b0;
    vin[1] = 32'hFE000EE3; vimm[1] = 32'hFFFFFFFC; vtyp[1] = 3'd3; vill[1] = 1'b0;
    vin[2] = 32'hFE002C23; vimm[2] = 32'hFFFFFFF8; vtyp[2] = 3'd2; vill[2] = 1'b0;
    vin[3] = 32'h0080006F; vimm[3] = 32'h00000008; vtyp[3] = 3'd5; vill[3] = 1'b0;
    vin[4] = 32'h12345037; vimm[4] = 32'h12345000; vtyp[4] = 3'd4; vill[4] = 1'b0;
    vin[5] = 32'h00000033; vimm[5] = 32'h0;        vtyp[5] = 3'd0; vill[5] = 1'b0;
    vin[6] = 32'h00000000; vimm[6] = 32'h0;        vtyp[6] = 3'd0; vill[6] = 1'b1;
    vin[7] = 32'hFFF0009B; vimm[7] = 32'h0;        vtyp[7] = 3'd0; vill[7] = 1'b1;
`ifdef IMMGEN_PIPE_ZICSR_EN
    vin[8] = 32'h3002D073; vimm[8] = 32'h00000005; vtyp[8] = 3'd6; vill[8] = 1'b0;
`else
    vin[8] = 32'h3002D073; vimm[8] = 32'h0;        vtyp[8] = 3'd0; vill[8] = 1'b1;
`endif
    i_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_inst  = vin[k];
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_imm !== vimm[k] || o_imm_type !== vtyp[k] ||
          o_illegal !== vill[k]) begin
        errors++;
        $display("FAIL decode[%0d] inst=%h: valid=%b imm=%h type=%0d ill=%b want 1 %h %0d %b",
                 k, vin[k], o_valid, o_imm, o_imm_type, o_illegal, vimm[k], vtyp[k], vill[k]);
      end
      step();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b want 0", k, o_valid);
      end
    end
  endtask

  task automatic test_xlen64();
    inst64 = 32'h80000037;
    v64    = 1'b1;
    step();
    inst64 = 32'hFFF0009B;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== 64'hFFFFFFFF80000000 || typ64 !== 3'd4 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL lui64: valid=%b imm=%h type=%0d ill=%b want 1 ffffffff80000000 4 0",
               ov64, imm64, typ64, ill64);
    end
    step();
    v64 = 1'b0;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFF || typ64 !== 3'd1 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL addiw64: valid=%b imm=%h type=%0d ill=%b want 1 ffffffffffffffff 1 0",
               ov64, imm64, typ64, ill64);
    end
    step();
  endtask

  // A, B, C offered while stalled; then released.
  task automatic test_back_to_back();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_inst  = 32'h00100093;   // A: imm 1
    step();
    i_inst  = 32'h00200093;   // B: imm 2
    step();
    i_inst  = 32'h00300093;   // C: imm 3
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_imm !== 32'd1) begin
      errors++;
      $display("FAIL stall_full: ready=%b valid=%b imm=%h want 0 1 1", o_ready, o_valid, o_imm);
    end
    step();
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_imm !== 32'd1 || o_imm_type !== 3'd1) begin
      errors++;
      $display("FAIL stall_hold: ready=%b valid=%b imm=%h type=%0d want 0 1 1 1",
               o_ready, o_valid, o_imm, o_imm_type);
    end
    i_ready = 1'b1;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_imm !== 32'd2 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL order_b: valid=%b imm=%h ready=%b want 1 2 1", o_valid, o_imm, o_ready);
    end
    step();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_imm !== 32'd3) begin
      errors++;
      $display("FAIL order_c: valid=%b imm=%h want 1 3", o_valid, o_imm);
    end
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_end: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_inst  = 32'h00100093;
    step();
    i_inst  = 32'h00200093;
    step();
    i_inst  = 32'h00400093;   // offered during flush, must vanish
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    i_ready = 1'b1;
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: valid=%b imm=%h want valid 0", o_valid, o_imm);
    end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_inst  = 32'hFFF00093;
    step();
    step();
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== 32'h0 ||
        o_imm_type !== 3'd0 || o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b imm=%h type=%0d ill=%b want 0 1 0 0 0",
               o_valid, o_ready, o_imm, o_imm_type, o_illegal);
    end
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_inst  = 32'h00700093;
    step();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_imm !== 32'd7) begin
      errors++;
      $display("FAIL post_reset: valid=%b imm=%h want 1 7", o_valid, o_imm);
    end
    step();
  endtask

  initial begin
    #3;
    test_reset();
    test_decode();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
